// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, constants and divider helper for the UART transmitter
//
// Purpose : serialiser state encoding, data-bit count, simulation divider and the
//           clocks-per-bit computation used by uart_tx_fifo.
// Ports   : none (package).
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_tx_state_t;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_SIM_DIV   = 4;

  // Clocks per bit. Simulation builds use a short fixed divider so frames stay cheap.
  function automatic int uart_div(input int clk_hz, input int baud, input int is_simulation);
    if (is_simulation != 0) begin
      return UART_SIM_DIV;
    end
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period counter producing one tick per DIV clocks
//
// Purpose : counts 0..DIV-1 while enabled; tick is high during the last count.
//           restart forces the count back to 0 so every frame starts phase-aligned.
// Ports   :
//   clk      in  1  system clock, rising edge
//   reset_n  in  1  asynchronous active-low reset
//   en       in  1  count enable (serialiser busy)
//   restart  in  1  clear count to 0 (byte popped into the serialiser)
//   tick     out 1  high while count == DIV-1
module uart_baud_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic restart,
  output logic tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] baud_cnt;

  assign tick = (baud_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      baud_cnt <= '0;
    end else if (restart) begin
      baud_cnt <= '0;
    end else if (en) begin
      if (tick) begin
        baud_cnt <= '0;
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - FIFO-buffered 8N1 UART transmitter
//
// Purpose : queues bytes from the upstream capture/dump FSM and serialises them
//           LSB-first as start, 8 data, stop. Back-to-back frames have no idle gap.
// Ports   :
//   clk              in  1  system clock, rising edge
//   reset_n          in  1  asynchronous active-low reset
//   uart_tx_data_we  in  1  write strobe, one byte per high cycle
//   uart_tx_data     in  8  byte to send, sampled with the strobe
//   uart_empty       out 1  FIFO holds no bytes (a frame may still be on the line)
//   uart_full        out 1  FIFO holds FIFO_DEPTH bytes
//   uart_done        out 1  FIFO empty and serialiser idle
//   overflow         out 1  sticky: a write was dropped while full
//   txd              out 1  serial output, idle high
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_HZ        = 50_000_000,
  parameter int BAUD          = 115200,
  parameter int FIFO_DEPTH    = 16,
  parameter int is_simulation = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       uart_tx_data_we,
  input  logic [7:0] uart_tx_data,
  output logic       uart_empty,
  output logic       uart_full,
  output logic       uart_done,
  output logic       overflow,
  output logic       txd
);

  localparam int DIV   = uart_div(CLK_HZ, BAUD, is_simulation);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [2:0]     LAST_BIT = 3'(UART_DATA_BITS - 1);

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [PTR_W:0]   count_nxt;

  uart_tx_state_t state;
  logic [7:0]     shift;
  logic [2:0]     bit_cnt;

  logic tick;
  logic wr_acc;
  logic pop;
  logic idle_nxt;

  // The registered full flag gates writes, so a pop in the same cycle cannot
  // make room for a byte arriving while full.
  assign wr_acc = uart_tx_data_we && !uart_full;

  always_comb begin
    pop      = 1'b0;
    idle_nxt = 1'b0;
    case (state)
      IDLE: begin
        pop      = !uart_empty;
        idle_nxt = uart_empty;
      end
      STOP: begin
        pop      = tick && !uart_empty;
        idle_nxt = tick && uart_empty;
      end
      default: begin
        pop      = 1'b0;
        idle_nxt = 1'b0;
      end
    endcase
  end

  always_comb begin
    count_nxt = count;
    if (wr_acc && !pop) begin
      count_nxt = count + 1'b1;
    end else if (!wr_acc && pop) begin
      count_nxt = count - 1'b1;
    end
  end

  uart_baud_gen #(
    .DIV(DIV)
  ) u_baud_gen (
    .clk    (clk),
    .reset_n(reset_n),
    .en     (state != IDLE),
    .restart(pop),
    .tick   (tick)
  );

  // Storage is not reset: contents are only read behind a non-zero count.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= uart_tx_data;
    end
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      uart_empty <= 1'b1;
      uart_full  <= 1'b0;
      uart_done  <= 1'b1;
      overflow   <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (uart_tx_data_we && uart_full) begin
        overflow <= 1'b1;
      end
      count      <= count_nxt;
      uart_empty <= (count_nxt == '0);
      uart_full  <= (count_nxt == CNT_FULL);
      uart_done  <= idle_nxt && (count_nxt == '0);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      shift   <= '0;
      bit_cnt <= '0;
      txd     <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            shift <= mem[rd_ptr];
            txd   <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (tick) begin
            txd     <= shift[0];
            shift   <= shift >> 1;
            bit_cnt <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_cnt == LAST_BIT) begin
              txd   <= 1'b1;
              state <= STOP;
            end else begin
              txd     <= shift[0];
              shift   <= shift >> 1;
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (pop) begin
              shift <= mem[rd_ptr];
              txd   <= 1'b0;
              state <= START;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
          txd   <= 1'b1;
        end
      endcase
    end
  end

endmodule
